// File: rtl/ooo_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ooo_pkg
//  Brief   : Shared out-of-order core types: CDB packet and round-robin helpers.
//  Rev     : 1.0  initial release
// ============================================================================
package ooo_pkg;

    localparam int DEF_TAG_WIDTH  = 5;
    localparam int DEF_DATA_WIDTH = 32;

    typedef struct packed {
        logic [DEF_TAG_WIDTH-1:0]  tag;
        logic [DEF_DATA_WIDTH-1:0] data;
        logic                      exc;
    } cdb_pkt_t;

    // Wrap an index that can overshoot by at most one lap; avoids a modulo.
    function automatic int rr_wrap(input int a, input int n);
        return (a >= n) ? (a - n) : a;
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage : ooo_pkg
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module  : cdb_arbiter_if
//  Brief   : FU request bundle plus CDB broadcast; slave = arbiter side.
//  Rev     : 1.0  initial release
// ============================================================================
interface cdb_arbiter_if
    import ooo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_exc_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic                          flush_i;
    logic                          rob_ready_i;
    logic                          cdb_valid_o;
    logic [TAG_WIDTH-1:0]          cdb_tag_o;
    logic [DATA_WIDTH-1:0]         cdb_data_o;
    logic                          cdb_exc_o;
    logic [IDX_W-1:0]              cdb_src_o;

    modport slave (
        input  req_valid_i, req_tag_i, req_data_i, req_exc_i, flush_i, rob_ready_i,
        output req_ready_o, cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_exc_o, cdb_src_o
    );

    modport master (
        output req_valid_i, req_tag_i, req_data_i, req_exc_i, flush_i, rob_ready_i,
        input  req_ready_o, cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_exc_o, cdb_src_o
    );

endinterface : cdb_arbiter_if
`default_nettype wire

// File: rtl/cdb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arbiter
//  Brief   : Combinational round-robin pick starting at ptr_i, wrapping at N-1.
//  Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter
    import ooo_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        gnt_o    = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand     = rr_wrap(int'(ptr_i) + k, N);
            cand_idx = IDX_W'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : cdb_arbiter
//  Brief   : Round-robin sharing of the CDB writeback port into a one-entry slot.
//  Rev     : 1.0  initial release
// ============================================================================
module cdb_arbiter
    import ooo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    cdb_arbiter_if.slave    bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
        logic                  exc;
    } slot_t;

    slot_t              slot_q,   slot_d;
    logic               valid_q,  valid_d;
    logic [IDX_W-1:0]   src_q,    src_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic               slot_free;
    logic               arb_en;
    logic               grant;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    slot_t              win_pkt;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i (bus.req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    // The slot frees up on the same beat the ROB takes it, so grants can stream.
    assign slot_free = !valid_q || bus.rob_ready_i;
    assign arb_en    = rst_n && slot_free && !bus.flush_i;
    assign grant     = arb_en && win_any;

    assign bus.req_ready_o = arb_en ? gnt : '0;

    always_comb begin
        win_pkt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_pkt.tag  = bus.req_tag_i[i*TAG_WIDTH +: TAG_WIDTH];
                win_pkt.data = bus.req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                win_pkt.exc  = bus.req_exc_i[i];
            end
        end
    end

    always_comb begin
        slot_d   = slot_q;
        valid_d  = valid_q;
        src_d    = src_q;
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            slot_d   = win_pkt;
            valid_d  = 1'b1;
            src_d    = win_idx;
            rr_ptr_d = IDX_W'(rr_next(int'(win_idx), NUM_REQ));
        end else if (bus.flush_i || bus.rob_ready_i) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= '0;
            valid_q  <= 1'b0;
            src_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            slot_q   <= slot_d;
            valid_q  <= valid_d;
            src_q    <= src_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.cdb_valid_o = valid_q;
    assign bus.cdb_tag_o   = slot_q.tag;
    assign bus.cdb_data_o  = slot_q.data;
    assign bus.cdb_exc_o   = slot_q.exc;
    assign bus.cdb_src_o   = src_q;

endmodule : cdb_arbiter
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_cdb_arbiter
//  Brief   : Scoreboard bench for cdb_arbiter against a round-robin reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;
    import ooo_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    cdb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        cdb_pkt_t pkt;
        int       src;
    } exp_t;

    exp_t          q[$];
    int            checks   = 0;
    int            failures = 0;

    logic [N-1:0]  pend = '0;
    logic [TW-1:0] tag_a  [N];
    logic [DW-1:0] data_a [N];
    logic          exc_a  [N];

    int            m_ptr   = 0;
    bit            m_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check and advance the model 1 time unit later.
    task automatic step(input logic [N-1:0] want, input logic rr, input logic fl,
                        input int force_fu = -1, input logic [TW-1:0] ftag = '0,
                        input logic [DW-1:0] fdata = '0, input logic rst_level = 1'b1);
        logic [N-1:0] exp_rdy;
        int           win;
        exp_t         e;
        @(negedge clk);
        rst_n = rst_level;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && want[i]) begin
                tag_a[i]  = TW'($urandom);
                data_a[i] = $urandom;
                exc_a[i]  = 1'($urandom_range(0, 1));
                if (i == force_fu) begin
                    tag_a[i]  = ftag;
                    data_a[i] = fdata;
                end
                pend[i] = 1'b1;
            end
            bus.req_tag_i[i*TW +: TW]  = tag_a[i];
            bus.req_data_i[i*DW +: DW] = data_a[i];
            bus.req_exc_i[i]           = exc_a[i];
        end
        bus.req_valid_i = pend;
        bus.rob_ready_i = rr;
        bus.flush_i     = fl;
        #1;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            q.delete();
        end
        exp_rdy = '0;
        win     = -1;
        if (rst_n && (!m_valid || rr) && !fl) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
        end
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
        chk("cdb_valid", 64'(bus.cdb_valid_o), 64'(m_valid));
        if (!rst_n) begin
            // nothing moves in reset
        end else if (fl) begin
            m_valid = 1'b0;
            pend    = '0;
        end else if (win >= 0) begin
            e.pkt.tag  = tag_a[win];
            e.pkt.data = data_a[win];
            e.pkt.exc  = exc_a[win];
            e.src      = win;
            q.push_back(e);
            m_valid   = 1'b1;
            m_ptr     = (win + 1) % N;
            pend[win] = 1'b0;
        end else if (rr) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(bus.cdb_valid_o), 64'd0);
        chk("async_ready", 64'(bus.req_ready_o), 64'd0);
        chk("async_src",   64'(bus.cdb_src_o),   64'd0);
        chk("async_tag",   64'(bus.cdb_tag_o),   64'd0);
    endtask

    task automatic drain();
        repeat (4) step('0, 1'b1, 1'b0);
    endtask

    // Monitor: every presented beat must match the oldest outstanding grant.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.cdb_valid_o) begin
                chk("beat_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q[0];
                    chk("cdb_tag",  64'(bus.cdb_tag_o),  64'(e.pkt.tag));
                    chk("cdb_data", 64'(bus.cdb_data_o), 64'(e.pkt.data));
                    chk("cdb_exc",  64'(bus.cdb_exc_o),  64'(e.pkt.exc));
                    chk("cdb_src",  64'(bus.cdb_src_o),  64'(e.src));
                    if (bus.rob_ready_i || bus.flush_i) void'(q.pop_front());
                end
            end
        end
    end

    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
        !bus.flush_i |=> ((($past(bus.req_valid_i) & ~$past(bus.req_ready_o)) & ~bus.req_valid_i) == '0))
        else $error("FAIL requester_hold: a pending request dropped before its grant");

    initial begin
        bus.req_valid_i = '0;
        bus.req_tag_i   = '0;
        bus.req_data_i  = '0;
        bus.req_exc_i   = '0;
        bus.flush_i     = 1'b0;
        bus.rob_ready_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            tag_a[i] = '0; data_a[i] = '0; exc_a[i] = 1'b0;
        end
        #1 rst_n = 1'b0;

        // Reset with random requests, then release: lowest valid index first.
        repeat (3) step(N'($urandom), 1'b1, 1'b0, -1, '0, '0, 1'b0);
        step('0, 1'b1, 1'b0);
        drain();

        // All requesters valid: strict rotation, one beat per cycle.
        repeat (8) step('1, 1'b1, 1'b0);
        drain();

        // Backpressure on a known FU2 beat, then FU3 takes the next grant.
        step(4'b0100, 1'b1, 1'b0, 2, 5'h0A, 32'hDEADBEEF);
        repeat (3) step(4'b1001, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
        drain();

        // Wrap: FU2 -> ptr 3, FU1 alone -> ptr 2, then FU3 before FU0.
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b1001, 1'b1, 1'b0);
        drain();

        // Flush while a beat is stalled and FU0 waits; FU0 wins afterwards.
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0001, 1'b0, 1'b1);
        step(4'b0001, 1'b1, 1'b0);
        drain();

        // Async reset between edges while a beat is presented.
        step(4'b0100, 1'b1, 1'b0);
        mid_reset();
        step('0, 1'b1, 1'b0, -1, '0, '0, 1'b0);
        step(4'b1010, 1'b1, 1'b0);
        drain();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                mid_reset();
                step(N'($urandom), 1'b1, 1'b0, -1, '0, '0, 1'b0);
            end
            step(N'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
        end
        drain();

        #20;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cdb_arbiter
`default_nettype wire
